// File: rtl/line_buffer_feeder_if.sv
// Line-buffer feeder bus: camera pixel stream in, line-buffer write port out.
// slave  : the feeder (consumes pixels, drives the write port)
// master : the camera / environment side
interface line_buffer_feeder_if;
  logic        sof;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic [31:0] datain;
  logic [8:0]  address;
  logic [8:0]  vertical_count;
  logic        save_data;

  modport slave (
    input  sof,
    input  pix_valid,
    input  pix_data,
    output datain,
    output address,
    output vertical_count,
    output save_data
  );

  modport master (
    output sof,
    output pix_valid,
    output pix_data,
    input  datain,
    input  address,
    input  vertical_count,
    input  save_data
  );
endinterface

// File: rtl/line_buffer_feeder.sv
// line_buffer_feeder: writer side of the camera line buffer.
// Packs four 8-bit pixels into each 32-bit word and writes one line per
// H_PIXELS pixels, tracking column/line position within the frame.
// Optional build macro FEEDER_FRAME_CNT_EN adds a 16-bit completed-frame
// counter output (frame_cnt); without it the port and counter do not exist.
module line_buffer_feeder #(
  parameter int H_PIXELS = 512,
  parameter int V_LINES  = 480
) (
  input  logic                clk,
  input  logic                rst_n,
  line_buffer_feeder_if.slave lb,
  input  logic                clr_err,
  output logic                busy,
  output logic                frame_done,
  output logic                err_sof,
  output logic                err_ovf
`ifdef FEEDER_FRAME_CNT_EN
  ,
  output logic [15:0]         frame_cnt
`endif
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [8:0] COL_LAST  = 9'(H_PIXELS - 1);
  localparam logic [8:0] LINE_LAST = 9'(V_LINES - 1);

  state_t      state_r;
  logic [8:0]  col_r;
  logic [8:0]  line_r;
  logic [31:0] pack_r;
  logic        done_seen_r;   // a frame completed since reset / last sof

  logic [31:0] datain_r;
  logic [8:0]  address_r;
  logic [8:0]  vertical_count_r;
  logic        save_data_r;
  logic        busy_r;
  logic        frame_done_r;
  logic        err_sof_r;
  logic        err_ovf_r;
`ifdef FEEDER_FRAME_CNT_EN
  logic [15:0] frame_cnt_r;
`endif

  logic        col_last_s;
  logic        line_last_s;
  logic        word_end_s;
  logic [31:0] word_s;

  // Place one pixel into its byte lane of the pack register.
  function automatic logic [31:0] insert_byte(input logic [31:0] pack,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  pix);
    logic [31:0] res;
    res = pack;
    case (lane)
      2'd0:    res[7:0]   = pix;
      2'd1:    res[15:8]  = pix;
      2'd2:    res[23:16] = pix;
      2'd3:    res[31:24] = pix;
      default: res        = pack;
    endcase
    return res;
  endfunction

  // Position decode and the completed word (current pixel fills the top lane).
  always_comb begin
    col_last_s  = (col_r == COL_LAST);
    line_last_s = (line_r == LINE_LAST);
    word_end_s  = (col_r[1:0] == 2'd3);
    word_s      = {lb.pix_data, pack_r[23:0]};
  end

  // Frame FSM with position counters, packing and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      col_r            <= 9'd0;
      line_r           <= 9'd0;
      pack_r           <= 32'd0;
      done_seen_r      <= 1'b0;
      datain_r         <= 32'd0;
      address_r        <= 9'd0;
      vertical_count_r <= 9'd0;
      save_data_r      <= 1'b0;
      busy_r           <= 1'b0;
      frame_done_r     <= 1'b0;
      err_sof_r        <= 1'b0;
      err_ovf_r        <= 1'b0;
`ifdef FEEDER_FRAME_CNT_EN
      frame_cnt_r      <= 16'd0;
`endif
    end else begin
      // strobes are single-cycle by default
      save_data_r  <= 1'b0;
      frame_done_r <= 1'b0;

      // clearing comes first so a simultaneous new error below overrides it
      if (clr_err) begin
        err_sof_r <= 1'b0;
        err_ovf_r <= 1'b0;
      end else begin
        err_sof_r <= err_sof_r;
        err_ovf_r <= err_ovf_r;
      end

      if (lb.sof) begin
        // restart the frame; any partial pack is dropped without a write
        if (state_r == ACTIVE) begin
          err_sof_r <= 1'b1;
        end else begin
          err_sof_r <= err_sof_r & ~clr_err;
        end
        state_r     <= ACTIVE;
        busy_r      <= 1'b1;
        line_r      <= 9'd0;
        done_seen_r <= 1'b0;
        if (lb.pix_valid) begin
          pack_r <= {24'd0, lb.pix_data};
          col_r  <= 9'd1;
        end else begin
          pack_r <= 32'd0;
          col_r  <= 9'd0;
        end
      end else begin
        case (state_r)
          IDLE: begin
            busy_r <= 1'b0;
            // stray pixel after a finished frame: flag and drop it
            if (lb.pix_valid && done_seen_r) begin
              err_ovf_r <= 1'b1;
            end else begin
              err_ovf_r <= err_ovf_r & ~clr_err;
            end
          end
          ACTIVE: begin
            busy_r <= 1'b1;
            if (lb.pix_valid) begin
              pack_r <= insert_byte(pack_r, col_r[1:0], lb.pix_data);
              if (word_end_s) begin
                datain_r         <= word_s;
                address_r        <= {col_r[8:2], 2'b00};
                vertical_count_r <= line_r;
                save_data_r      <= 1'b1;
              end else begin
                datain_r         <= datain_r;
              end
              if (col_last_s) begin
                col_r <= 9'd0;
                if (line_last_s) begin
                  // final word of the frame: close it out in the same cycle
                  line_r       <= 9'd0;
                  state_r      <= IDLE;
                  busy_r       <= 1'b0;
                  frame_done_r <= 1'b1;
                  done_seen_r  <= 1'b1;
`ifdef FEEDER_FRAME_CNT_EN
                  frame_cnt_r  <= frame_cnt_r + 16'd1;
`endif
                end else begin
                  line_r <= line_r + 9'd1;
                end
              end else begin
                col_r <= col_r + 9'd1;
              end
            end else begin
              // gap in the stream: hold everything
              col_r <= col_r;
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign lb.datain         = datain_r;
  assign lb.address        = address_r;
  assign lb.vertical_count = vertical_count_r;
  assign lb.save_data      = save_data_r;
  assign busy              = busy_r;
  assign frame_done        = frame_done_r;
  assign err_sof           = err_sof_r;
  assign err_ovf           = err_ovf_r;
`ifdef FEEDER_FRAME_CNT_EN
  assign frame_cnt         = frame_cnt_r;
`endif

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Testbench for line_buffer_feeder (H_PIXELS=8, V_LINES=2).
// Cycle table for the directed cases, scoreboard for gapped whole frames.
module tb_line_buffer_feeder;

  localparam int H = 8;
  localparam int V = 2;

  logic clk;
  logic rst_n;
  logic clr_err;
  logic busy, frame_done, err_sof, err_ovf;
`ifdef FEEDER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  line_buffer_feeder_if lbi ();

  line_buffer_feeder #(.H_PIXELS(H), .V_LINES(V)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lb         (lbi),
    .clr_err    (clr_err),
    .busy       (busy),
    .frame_done (frame_done),
    .err_sof    (err_sof),
    .err_ovf    (err_ovf)
`ifdef FEEDER_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sof;
    logic        pv;
    logic [7:0]  data;
    logic        clr;
    logic        save;
    logic [31:0] din;
    logic [8:0]  addr;
    logic [8:0]  vc;
    logic        done;
    logic        busy;
    logic        esof;
    logic        eovf;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input int sof, input int pv, input int data, input int clr,
                      input int save, input logic [31:0] din, input int addr, input int vc,
                      input int done, input int bsy, input int esof, input int eovf);
    vec_t v;
    v.sof  = (sof != 0);
    v.pv   = (pv != 0);
    v.data = 8'(data);
    v.clr  = (clr != 0);
    v.save = (save != 0);
    v.din  = din;
    v.addr = 9'(addr);
    v.vc   = 9'(vc);
    v.done = (done != 0);
    v.busy = (bsy != 0);
    v.esof = (esof != 0);
    v.eovf = (eovf != 0);
    vecs.push_back(v);
  endtask

  typedef struct {
    logic [31:0] din;
    logic [8:0]  addr;
    logic [8:0]  vc;
    logic        done;
  } word_t;

  word_t sbq[$];
  logic  sb_on = 1'b0;

  // Scoreboard monitor: every write strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (sb_on) begin
      if (lbi.save_data) begin
        if (sbq.size() == 0) begin
          chk("sb_extra_save", {31'd0, lbi.save_data}, 32'd0);
        end else begin
          word_t e;
          e = sbq.pop_front();
          chk("sb_datain", lbi.datain, e.din);
          chk("sb_address", {23'd0, lbi.address}, {23'd0, e.addr});
          chk("sb_vcount", {23'd0, lbi.vertical_count}, {23'd0, e.vc});
          chk("sb_frame_done", {31'd0, frame_done}, {31'd0, e.done});
        end
      end else begin
        chk("sb_done_without_save", {31'd0, frame_done}, 32'd0);
      end
    end
  end

  task automatic drive(input logic s, input logic pv, input logic [7:0] d, input logic c);
    lbi.sof       = s;
    lbi.pix_valid = pv;
    lbi.pix_data  = d;
    clr_err       = c;
    @(posedge clk);
    #1;
    lbi.sof       = 1'b0;
    lbi.pix_valid = 1'b0;
    clr_err       = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_save"}, {31'd0, lbi.save_data}, 32'd0);
    chk({tag, "_datain"}, lbi.datain, 32'd0);
    chk({tag, "_addr"}, {23'd0, lbi.address}, 32'd0);
    chk({tag, "_vc"}, {23'd0, lbi.vertical_count}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_err_sof"}, {31'd0, err_sof}, 32'd0);
    chk({tag, "_err_ovf"}, {31'd0, err_ovf}, 32'd0);
  endtask

  // Drive pixels of (part of) a frame with random gaps, pushing expected words.
  task automatic send_pixels(input int tag, input int n_pix, input bit with_sof);
    logic [31:0] acc;
    logic [7:0]  p;
    acc = 32'd0;
    if (with_sof) drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < n_pix; k++) begin
      int ln, cl;
      ln = k / H;
      cl = k % H;
      if ($urandom_range(0, 1) == 1) drive(1'b0, 1'b0, 8'h00, 1'b0);
      p = 8'(tag * 32 + ln * 8 + cl);
      acc[(cl % 4) * 8 +: 8] = p;
      if ((cl % 4) == 3) begin
        word_t w;
        w.din  = acc;
        w.addr = 9'(cl - 3);
        w.vc   = 9'(ln);
        w.done = (ln == V - 1) && (cl == H - 1);
        sbq.push_back(w);
      end
      drive(1'b0, 1'b1, p, 1'b0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    lbi.sof       = 1'b0;
    lbi.pix_valid = 1'b0;
    lbi.pix_data  = 8'h00;
    clr_err       = 1'b0;

    // sof, pv, data, clr | save, datain, addr, vc, done, busy, err_sof, err_ovf
    addv(0,1,'h99,0, 0,32'h00000000,0,0, 0,0,0,0);
    addv(1,0,'h00,0, 0,32'h00000000,0,0, 0,1,0,0);
    addv(0,1,'h00,0, 0,32'h00000000,0,0, 0,1,0,0);
    addv(0,1,'h01,0, 0,32'h00000000,0,0, 0,1,0,0);
    addv(0,1,'h02,0, 0,32'h00000000,0,0, 0,1,0,0);
    addv(0,1,'h03,0, 1,32'h03020100,0,0, 0,1,0,0);
    addv(0,1,'h04,0, 0,32'h03020100,0,0, 0,1,0,0);
    addv(0,1,'h05,0, 0,32'h03020100,0,0, 0,1,0,0);
    addv(0,1,'h06,0, 0,32'h03020100,0,0, 0,1,0,0);
    addv(0,1,'h07,0, 1,32'h07060504,4,0, 0,1,0,0);
    addv(0,1,'h10,0, 0,32'h07060504,4,0, 0,1,0,0);
    addv(0,1,'h11,0, 0,32'h07060504,4,0, 0,1,0,0);
    addv(0,1,'h12,0, 0,32'h07060504,4,0, 0,1,0,0);
    addv(0,1,'h13,0, 1,32'h13121110,0,1, 0,1,0,0);
    addv(0,1,'h14,0, 0,32'h13121110,0,1, 0,1,0,0);
    addv(0,1,'h15,0, 0,32'h13121110,0,1, 0,1,0,0);
    addv(0,1,'h16,0, 0,32'h13121110,0,1, 0,1,0,0);
    addv(0,1,'h17,0, 1,32'h17161514,4,1, 1,0,0,0);
    addv(0,1,'h55,0, 0,32'h17161514,4,1, 0,0,0,1);
    addv(0,0,'h00,1, 0,32'h17161514,4,1, 0,0,0,0);
    addv(1,1,'hAA,0, 0,32'h17161514,4,1, 0,1,0,0);
    addv(0,1,'hBB,0, 0,32'h17161514,4,1, 0,1,0,0);
    addv(0,1,'hCC,0, 0,32'h17161514,4,1, 0,1,0,0);
    addv(0,1,'hDD,0, 1,32'hDDCCBBAA,0,0, 0,1,0,0);
    addv(0,1,'h01,0, 0,32'hDDCCBBAA,0,0, 0,1,0,0);
    addv(0,1,'h02,0, 0,32'hDDCCBBAA,0,0, 0,1,0,0);
    addv(1,1,'h30,0, 0,32'hDDCCBBAA,0,0, 0,1,1,0);
    addv(0,1,'h31,0, 0,32'hDDCCBBAA,0,0, 0,1,1,0);
    addv(0,1,'h32,0, 0,32'hDDCCBBAA,0,0, 0,1,1,0);
    addv(0,1,'h33,0, 1,32'h33323130,0,0, 0,1,1,0);
    addv(0,0,'h00,1, 0,32'h33323130,0,0, 0,1,0,0);
    addv(1,1,'h40,1, 0,32'h33323130,0,0, 0,1,1,0);

    // reset state
    #3;
    chk_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // cycle-accurate table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sof, vecs[i].pv, vecs[i].data, vecs[i].clr);
      chk($sformatf("v%0d_save", i), {31'd0, lbi.save_data}, {31'd0, vecs[i].save});
      chk($sformatf("v%0d_datain", i), lbi.datain, vecs[i].din);
      chk($sformatf("v%0d_addr", i), {23'd0, lbi.address}, {23'd0, vecs[i].addr});
      chk($sformatf("v%0d_vc", i), {23'd0, lbi.vertical_count}, {23'd0, vecs[i].vc});
      chk($sformatf("v%0d_done", i), {31'd0, frame_done}, {31'd0, vecs[i].done});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      chk($sformatf("v%0d_err_sof", i), {31'd0, err_sof}, {31'd0, vecs[i].esof});
      chk($sformatf("v%0d_err_ovf", i), {31'd0, err_ovf}, {31'd0, vecs[i].eovf});
    end

    // asynchronous reset mid-line, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // gapped whole frames through the scoreboard, plus one aborted frame
    sb_on = 1'b1;
    send_pixels(0, H * V, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("f0_busy_low", {31'd0, busy}, 32'd0);
    send_pixels(1, H * V, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("f1_busy_low", {31'd0, busy}, 32'd0);
    send_pixels(2, 5, 1'b1);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    send_pixels(3, H * V, 1'b1);
    chk("f3_err_sof", {31'd0, err_sof}, 32'd1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("f3_busy_low", {31'd0, busy}, 32'd0);
    chk("sb_leftover", 32'(sbq.size()), 32'd0);
`ifdef FEEDER_FRAME_CNT_EN
    chk("frame_cnt", {16'd0, frame_cnt}, 32'd3);
`endif
    sb_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
